// File: rtl/piece_bag_pkg.sv
// Shared definitions for the piece bag: shape encoding, bag size, LFSR constants
// and small mask helpers.
package piece_bag_pkg;

   typedef enum logic [2:0] {
      SHAPE_O = 3'd0,
      SHAPE_I = 3'd1,
      SHAPE_S = 3'd2,
      SHAPE_Z = 3'd3,
      SHAPE_L = 3'd4,
      SHAPE_J = 3'd5,
      SHAPE_T = 3'd6
   } shape_e;

   localparam int          NUM_SHAPES   = 7;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [6:0]  FULL_BAG     = 7'h7F;

   function automatic logic [2:0] popCount7(input logic [6:0] mask);
      logic [2:0] count;
      count = 3'd0;
      for (int i = 0; i < NUM_SHAPES; i++) begin
         count = count + {2'b00, mask[i]};
      end
      return count;
   endfunction

   // Scanning downward leaves the lowest set index as the final winner.
   function automatic logic [2:0] lowestSet(input logic [6:0] mask);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = 3'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/piece_bag_lfsr.sv
// 16-bit Galois LFSR with an entropy bit folded into bit 0 and recovery from
// the all-zero lock-up state.
module lfsr16
   import piece_bag_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_mix,
   output logic [15:0] o_state
);

   logic [15:0] r_state;
   logic [15:0] w_next;

   always_comb begin
      w_next    = {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
      w_next[0] = w_next[0] ^ i_mix;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= SEED;
      end else if (w_next == 16'h0000) begin
         r_state <= SEED;
      end else begin
         r_state <= w_next;
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/piece_bag.sv
// 7-bag random piece generator: draws shapes without replacement from an LFSR
// and presents a two-entry (current + preview) queue to the game logic.
module piece_bag
   import piece_bag_pkg::*;
#(
   parameter logic [15:0] SEED       = DEFAULT_SEED,
   parameter int          MAX_REJECT = 8
) (
   input  logic       VGA_CLK,
   input  logic       reset,
   input  logic       take,
   input  logic       mix,
   output logic       piece_valid,
   output logic [2:0] piece_id,
   output logic       next_valid,
   output logic [2:0] next_id,
   output logic [2:0] bag_count
);

   localparam int           RW        = $clog2(MAX_REJECT + 1);
   localparam logic [RW-1:0] REJ_LIMIT = RW'(MAX_REJECT);

   logic [15:0]   w_lfsr;
   logic [6:0]    r_mask;
   logic [RW-1:0] r_rejects;
   logic          r_curValid;
   logic          r_nxtValid;
   logic [2:0]    r_curId;
   logic [2:0]    r_nxtId;

   logic          w_take;
   logic          w_attempt;
   logic [2:0]    w_cand;
   logic [7:0]    w_maskExt;
   logic          w_forced;
   logic          w_candOk;
   logic          w_accept;
   logic [2:0]    w_drawId;
   logic [6:0]    w_maskCleared;
   logic [6:0]    w_maskNext;

   lfsr16 #(.SEED(SEED)) u_lfsr (
      .i_clk   (VGA_CLK),
      .i_reset (reset),
      .i_mix   (mix),
      .o_state (w_lfsr)
   );

   // A take frees a slot, so a draw may proceed even from a full queue.
   always_comb begin
      w_take        = take & r_curValid;
      w_attempt     = ~(r_curValid & r_nxtValid) | w_take;
      w_cand        = w_lfsr[2:0];
      w_maskExt     = {1'b0, r_mask};
      w_forced      = (r_rejects >= REJ_LIMIT);
      w_candOk      = (w_cand != 3'd7) & w_maskExt[w_cand];
      w_accept      = w_attempt & (w_forced | w_candOk);
      w_drawId      = w_forced ? lowestSet(r_mask) : w_cand;
      w_maskCleared = r_mask & ~(7'b0000001 << w_drawId);
      w_maskNext    = r_mask;
      if (w_accept) begin
         w_maskNext = (w_maskCleared == 7'd0) ? FULL_BAG : w_maskCleared;
      end
   end

   always_ff @(posedge VGA_CLK) begin
      if (reset) begin
         r_mask     <= FULL_BAG;
         r_rejects  <= '0;
         r_curValid <= 1'b0;
         r_nxtValid <= 1'b0;
         r_curId    <= 3'd0;
         r_nxtId    <= 3'd0;
      end else begin
         r_mask <= w_maskNext;
         if (w_attempt) begin
            r_rejects <= w_accept ? '0 : r_rejects + 1'b1;
         end
         // On a take the preview shifts forward and a new draw fills whichever slot opened.
         if (w_take) begin
            if (r_nxtValid) begin
               r_curId    <= r_nxtId;
               r_nxtValid <= w_accept;
               if (w_accept) begin
                  r_nxtId <= w_drawId;
               end
            end else begin
               r_curValid <= w_accept;
               if (w_accept) begin
                  r_curId <= w_drawId;
               end
            end
         end else if (w_accept) begin
            if (!r_curValid) begin
               r_curValid <= 1'b1;
               r_curId    <= w_drawId;
            end else begin
               r_nxtValid <= 1'b1;
               r_nxtId    <= w_drawId;
            end
         end
      end
   end

   assign piece_valid = r_curValid;
   assign piece_id    = r_curId;
   assign next_valid  = r_nxtValid;
   assign next_id     = r_nxtId;
   assign bag_count   = popCount7(r_mask);

endmodule

// File: tb/tb_piece_bag.sv
// Self-checking bench for piece_bag: a queue/array model of the bag tracks the
// expected outputs every cycle, alongside a few hand-computed expectations.
module tb_piece_bag;
   import piece_bag_pkg::*;

   localparam int          MAXREJ = 8;
   localparam logic [15:0] SEED_V = 16'hACE1;

   logic       VGA_CLK = 1'b0;
   logic       reset   = 1'b1;
   logic       take    = 1'b0;
   logic       mix     = 1'b0;
   logic       piece_valid;
   logic [2:0] piece_id;
   logic       next_valid;
   logic [2:0] next_id;
   logic [2:0] bag_count;

   int checks = 0;
   int errors = 0;

   always #5 VGA_CLK = ~VGA_CLK;

   piece_bag #(.SEED(SEED_V), .MAX_REJECT(MAXREJ)) dut (
      .VGA_CLK     (VGA_CLK),
      .reset       (reset),
      .take        (take),
      .mix         (mix),
      .piece_valid (piece_valid),
      .piece_id    (piece_id),
      .next_valid  (next_valid),
      .next_id     (next_id),
      .bag_count   (bag_count)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Behavioural model: LFSR as plain integer arithmetic, bag as availability flags,
   // output queue as a SystemVerilog queue.
   int mLfsr;
   bit mAvail[7];
   int mRej;
   int mQ[$];
   int mCount;
   int mPick;
   int mCand;
   bit mFull;
   bit mTake;
   bit mAny;
   bit started = 1'b0;

   logic [7:0] grpSeen;
   int grpCnt;
   int seqLog[$];
   int firstSeq[$];
   int emptyRun = 0;

   function automatic int stepLfsr(input int s, input bit m);
      int n;
      n = s >> 1;
      if (s % 2 == 1) n = n ^ 'hB400;
      n = n ^ int'(m);
      if (n == 0) n = int'(SEED_V);
      return n;
   endfunction

   // Model advance and delivery scoreboard, both on the active edge using pre-edge values.
   always @(posedge VGA_CLK) begin
      if (reset) begin
         mLfsr = int'(SEED_V);
         for (int i = 0; i < 7; i++) mAvail[i] = 1'b1;
         mRej = 0;
         mQ.delete();
         grpSeen = 8'h00;
         grpCnt = 0;
         seqLog.delete();
      end else begin
         if (take && piece_valid) begin
            grpSeen[piece_id] = 1'b1;
            grpCnt++;
            seqLog.push_back(int'(piece_id));
            if (grpCnt == 7) begin
               checkOutput("perm7", 32'(grpSeen), 32'h7F);
               grpSeen = 8'h00;
               grpCnt = 0;
            end
         end
         mFull = (mQ.size() == 2);
         mTake = take && (mQ.size() > 0);
         mPick = -1;
         if (!mFull || mTake) begin
            mCand = mLfsr % 8;
            if (mRej >= MAXREJ) begin
               for (int i = 6; i >= 0; i--) if (mAvail[i]) mPick = i;
            end else if (mCand < 7 && mAvail[mCand]) begin
               mPick = mCand;
            end else begin
               mRej++;
            end
         end
         if (mTake) void'(mQ.pop_front());
         if (mPick >= 0) begin
            mQ.push_back(mPick);
            mAvail[mPick] = 1'b0;
            mRej = 0;
            mAny = 1'b0;
            for (int i = 0; i < 7; i++) mAny = mAny | mAvail[i];
            if (!mAny) for (int i = 0; i < 7; i++) mAvail[i] = 1'b1;
         end
         mLfsr = stepLfsr(mLfsr, mix);
      end
      started = 1'b1;
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge VGA_CLK) begin
      if (started) begin
         mCount = 0;
         for (int i = 0; i < 7; i++) mCount += int'(mAvail[i]);
         checkOutput("piece_valid", 32'(piece_valid), 32'(mQ.size() >= 1));
         checkOutput("next_valid", 32'(next_valid), 32'(mQ.size() >= 2));
         if (mQ.size() >= 1) checkOutput("piece_id", 32'(piece_id), 32'(mQ[0]));
         if (mQ.size() >= 2) checkOutput("next_id", 32'(next_id), 32'(mQ[1]));
         checkOutput("bag_count", 32'(bag_count), 32'(mCount));
         checkOutput("lfsr_nonzero", 32'(dut.w_lfsr != 16'h0000), 32'd1);
         if (reset) begin
            emptyRun = 0;
         end else if (!piece_valid) begin
            emptyRun++;
            if (emptyRun == MAXREJ + 2) checkOutput("draw_latency", 32'(emptyRun), 32'(MAXREJ + 1));
         end else begin
            if (emptyRun > 0) checkOutput("draw_latency_ok", 32'(emptyRun <= MAXREJ + 1), 32'd1);
            emptyRun = 0;
         end
      end
   end

   task automatic applyReset();
      @(posedge VGA_CLK);
      #1;
      reset = 1'b1;
      take  = 1'b0;
      repeat (3) @(posedge VGA_CLK);
      #1;
      reset = 1'b0;
   endtask

   // Takes a piece on every cycle one is presented, until nTakes have been delivered.
   task automatic applyStimulus(input int nTakes);
      int got;
      int guard;
      got = 0;
      guard = 0;
      while (got < nTakes && guard < nTakes * 20 + 50) begin
         take = piece_valid;
         if (piece_valid) got++;
         @(posedge VGA_CLK);
         #1;
         guard++;
      end
      take = 1'b0;
      if (got < nTakes) checkOutput("take_timeout", 32'(got), 32'(nTakes));
   endtask

   initial begin
      // Idle after reset: queue fills and then holds. Seed 16'hACE1 gives candidate 1,
      // and the next LFSR value 16'hE270 gives candidate 0.
      applyReset();
      repeat (2) @(posedge VGA_CLK);
      #1;
      checkOutput("lit_first_valid", 32'(piece_valid & next_valid), 32'd1);
      checkOutput("lit_first_id", 32'(piece_id), 32'd1);
      checkOutput("lit_next_id", 32'(next_id), 32'd0);
      checkOutput("lit_bag_count", 32'(bag_count), 32'd5);
      repeat (100) @(posedge VGA_CLK);
      #1;
      checkOutput("lit_hold_id", 32'(piece_id), 32'd1);
      checkOutput("lit_hold_next", 32'(next_id), 32'd0);
      checkOutput("lit_hold_bag", 32'(bag_count), 32'd5);

      // Continuous takes over ten bags; the reference sequence is kept for the repeat test.
      applyReset();
      applyStimulus(70);
      for (int i = 0; i < 14; i++) firstSeq.push_back(seqLog[i]);
      checkOutput("lit_seq0", 32'(firstSeq[0]), 32'd1);
      checkOutput("lit_seq1", 32'(firstSeq[1]), 32'd0);

      // take held right out of reset.
      applyReset();
      take = 1'b1;
      repeat (5) @(posedge VGA_CLK);
      #1;
      take = 1'b0;
      applyStimulus(12);

      // Reset mid-bag, then the sequence must replay identically.
      applyReset();
      applyStimulus(3);
      reset = 1'b1;
      @(posedge VGA_CLK);
      #1;
      checkOutput("lit_reset_valid", 32'(piece_valid), 32'd0);
      checkOutput("lit_reset_bag", 32'(bag_count), 32'd7);
      repeat (2) @(posedge VGA_CLK);
      #1;
      reset = 1'b0;
      applyStimulus(14);
      for (int i = 0; i < 14; i++) checkOutput("replay_seq", 32'(seqLog[i]), 32'(firstSeq[i]));

      // Random entropy and random takes.
      applyReset();
      for (int i = 0; i < 10000; i++) begin
         mix  = 1'($urandom_range(0, 1));
         take = 1'($urandom_range(0, 1));
         @(posedge VGA_CLK);
         #1;
      end
      mix  = 1'b0;
      take = 1'b0;
      @(negedge VGA_CLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
